// File: rtl/byte_reg_pkg.sv
// Shared types and command-byte layout for the byte-stream register bridge.
package byte_reg_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_DATA = 2'd1,
      RD_DATA = 2'd2
   } bridge_state_t;

   localparam int CMD_WR_BIT  = 7;
   localparam int CMD_IDX_MSB = 3;
   localparam int REG_BYTES   = 4;
   localparam int IDX_W       = CMD_IDX_MSB + 1;

endpackage

// File: rtl/byte_reg_bridge_if.sv
// Host byte streams plus register-bank write/read lines of the bridge.
// slave = bridge side, master = host link and register bank side.
interface byte_reg_bridge_if #(parameter int NUM_REGS = 8);
   import byte_reg_pkg::*;

   logic [7:0]                      rx_data;
   logic                            rx_valid;
   logic                            rx_ready;
   logic [7:0]                      tx_data;
   logic                            tx_valid;
   logic                            tx_ready;
   logic [NUM_REGS-1:0]             reg_we;
   logic [1:0]                      byte_sel;
   logic [7:0]                      byte_in;
   logic [NUM_REGS*REG_BYTES*8-1:0] reg_rdata;
   logic                            busy;

   modport slave (
      input  rx_data, rx_valid, tx_ready, reg_rdata,
      output rx_ready, tx_data, tx_valid, reg_we, byte_sel, byte_in, busy
   );

   modport master (
      output rx_data, rx_valid, tx_ready, reg_rdata,
      input  rx_ready, tx_data, tx_valid, reg_we, byte_sel, byte_in, busy
   );

endinterface

// File: rtl/byte_reg_bridge.sv
// Framed byte commands -> 4 byte-lane writes, or a 32-bit snapshot read back as 4 tx bytes.
// Write strobes and tx byte are registered (1 cycle); rx stalls only while a read drains.
module byte_reg_bridge
   import byte_reg_pkg::*;
#(
   parameter int NUM_REGS  = 8,
   parameter int REG_WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   byte_reg_bridge_if.slave  bus
);

   bridge_state_t        state_q, state_d;
   logic [1:0]           cnt_q, cnt_d, cnt_nxt;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [REG_WIDTH-1:0] snap_q, snap_d, rd_word;
   logic [NUM_REGS-1:0]  reg_we_q, reg_we_d, idx_onehot;
   logic [1:0]           byte_sel_q, byte_sel_d;
   logic [7:0]           byte_in_q, byte_in_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 rx_rdy, rx_fire, tx_fire, last_byte;

   assign rx_rdy    = (state_q != RD_DATA);
   assign rx_fire   = bus.rx_valid && rx_rdy;
   assign tx_fire   = tx_valid_q && bus.tx_ready;
   assign cnt_nxt   = cnt_q + 2'd1;
   assign last_byte = (cnt_q == 2'(REG_BYTES - 1));

   // Out-of-range indices match no register, so they read as zero and strobe nothing.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bus.rx_data[CMD_IDX_MSB:0] == IDX_W'(i))
            rd_word = bus.reg_rdata[i*REG_WIDTH +: REG_WIDTH];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++)
         idx_onehot[i] = (idx_q == IDX_W'(i));
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      snap_d     = snap_q;
      reg_we_d   = '0;
      byte_sel_d = 2'd0;
      byte_in_d  = 8'd0;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;

      unique case (state_q)
         IDLE: begin
            if (rx_fire) begin
               idx_d = bus.rx_data[CMD_IDX_MSB:0];
               cnt_d = 2'd0;
               if (bus.rx_data[CMD_WR_BIT]) begin
                  state_d = WR_DATA;
               end else begin
                  state_d    = RD_DATA;
                  snap_d     = rd_word;
                  tx_data_d  = rd_word[7:0];
                  tx_valid_d = 1'b1;
               end
            end
         end
         WR_DATA: begin
            if (rx_fire) begin
               reg_we_d   = idx_onehot;
               byte_sel_d = cnt_q;
               byte_in_d  = bus.rx_data;
               cnt_d      = cnt_nxt;
               if (last_byte)
                  state_d = IDLE;
            end
         end
         RD_DATA: begin
            if (tx_fire) begin
               cnt_d = cnt_nxt;
               if (last_byte) begin
                  tx_valid_d = 1'b0;
                  state_d    = IDLE;
               end else begin
                  tx_data_d = snap_q[{cnt_nxt, 3'b000} +: 8];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         idx_q      <= '0;
         snap_q     <= '0;
         reg_we_q   <= '0;
         byte_sel_q <= 2'd0;
         byte_in_q  <= 8'd0;
         tx_data_q  <= 8'd0;
         tx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         snap_q     <= snap_d;
         reg_we_q   <= reg_we_d;
         byte_sel_q <= byte_sel_d;
         byte_in_q  <= byte_in_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign bus.rx_ready = rx_rdy;
   assign bus.busy     = (state_q != IDLE);
   assign bus.reg_we   = reg_we_q;
   assign bus.byte_sel = byte_sel_q;
   assign bus.byte_in  = byte_in_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_byte_reg_bridge.sv
// Bench for byte_reg_bridge: emulates the register bank, keeps a word-level model of it,
// and checks write strobes and read-back bytes for directed and random frames.
module tb_byte_reg_bridge;

   localparam int NR = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   byte_reg_bridge_if #(.NUM_REGS(NR)) bus();

   byte_reg_bridge #(.NUM_REGS(NR), .REG_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] bank     [NR];
   logic [31:0] poke_val [NR];
   logic [NR-1:0] poke_en;
   logic        bank_clr;
   logic [31:0] mregs    [NR];
   int          we_pulses = 0;

   always_comb begin
      for (int i = 0; i < NR; i++)
         bus.reg_rdata[i*32 +: 32] = poke_en[i] ? poke_val[i] : bank[i];
   end

   // Register bank emulation: byte-enable registers sharing byte_sel/byte_in.
   always @(posedge clk) begin
      if (bank_clr) begin
         for (int i = 0; i < NR; i++) bank[i] <= 32'h0;
      end else begin
         for (int i = 0; i < NR; i++)
            if (bus.reg_we[i]) bank[i][{bus.byte_sel, 3'b000} +: 8] <= bus.byte_in;
      end
      if (|bus.reg_we) we_pulses <= we_pulses + 1;
   end

   function automatic logic [7:0] exp_onehot(input int idx);
      return (idx < NR) ? (8'd1 << idx) : 8'd0;
   endfunction

   function automatic logic [31:0] exp_read(input int idx);
      return (idx < NR) ? mregs[idx] : 32'h0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acc = 1'b0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      for (int c = 0; c < 100 && !acc; c++) begin
         acc = bus.rx_ready;
         tick();
      end
      bus.rx_valid = 1'b0;
      if (!acc) begin
         n_cmp++; n_bad++;
         $display("FAIL rx_accept_timeout: rx_ready=%b required 1", bus.rx_ready);
      end
   endtask

   // Drains one read response; returns the assembled word and protocol-violation counts.
   task automatic collect_read(input bit stall, output logic [31:0] word, output int unstable,
                               output int rx_rdy_hi, output int cycles);
      int k = 0;
      logic [7:0] pd = 8'h0;
      bit pstall = 1'b0;
      word = 32'h0; unstable = 0; rx_rdy_hi = 0; cycles = 0;
      while (k < 4) begin
         if (cycles > 300) begin
            unstable++;
            break;
         end
         bus.tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (pstall && bus.tx_data !== pd) unstable++;
         if (bus.tx_valid !== 1'b1) unstable++;
         if (bus.rx_ready !== 1'b0) rx_rdy_hi++;
         pd     = bus.tx_data;
         pstall = !bus.tx_ready;
         if (bus.tx_valid === 1'b1 && bus.tx_ready) begin
            word[k*8 +: 8] = bus.tx_data;
            k++;
         end
         tick();
         cycles++;
      end
      bus.tx_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; bank_clr = 1'b1;
      bus.rx_valid = 1'b0; bus.rx_data = 8'h0; bus.tx_ready = 1'b0; poke_en = '0;
      for (int i = 0; i < NR; i++) begin poke_val[i] = 32'h0; mregs[i] = 32'h0; end
      repeat (3) tick();
      n_cmp++;
      if ({bus.reg_we, bus.byte_sel, bus.byte_in, bus.tx_valid, bus.tx_data, bus.busy} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: we=%h sel=%h in=%h txv=%b txd=%h busy=%b required all 0",
                  bus.reg_we, bus.byte_sel, bus.byte_in, bus.tx_valid, bus.tx_data, bus.busy);
      end
      rst = 1'b0; bank_clr = 1'b0;
      tick();
      n_cmp++;
      if (bus.rx_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release: rx_ready=%b busy=%b required 1/0", bus.rx_ready, bus.busy);
      end
   endtask

   task automatic test_write_b2b();
      logic [31:0] w = 32'h11223344;
      int p0;
      send_byte(8'h82);
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.reg_we !== 8'h00) begin
         n_bad++;
         $display("FAIL wr_cmd_state: busy=%b we=%h required 1/00", bus.busy, bus.reg_we);
      end
      p0 = we_pulses;
      for (int k = 0; k < 4; k++) begin
         send_byte(w[k*8 +: 8]);
         n_cmp++;
         if ({bus.reg_we, bus.byte_sel, bus.byte_in} !== {exp_onehot(2), 2'(k), w[k*8 +: 8]}) begin
            n_bad++;
            $display("FAIL wr_b2b_lane%0d: we=%h sel=%0d in=%h required %h/%0d/%h", k,
                     bus.reg_we, bus.byte_sel, bus.byte_in, exp_onehot(2), k, w[k*8 +: 8]);
         end
      end
      mregs[2] = w;
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_bad++; $display("FAIL wr_b2b_busy_after: busy=%b required 0", bus.busy);
      end
      tick();
      n_cmp++;
      if (we_pulses - p0 !== 4 || bus.reg_we !== 8'h00) begin
         n_bad++;
         $display("FAIL wr_b2b_pulses: pulses=%0d we=%h required 4/00", we_pulses - p0, bus.reg_we);
      end
   endtask

   task automatic test_read_basic();
      logic [31:0] w; int uns, rxh, cyc;
      poke_val[5] = 32'hDEADBEEF; poke_en[5] = 1'b1;
      bus.tx_ready = 1'b1;
      send_byte(8'h05);
      n_cmp++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hEF || bus.rx_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_latency: txv=%b txd=%h rx_ready=%b required 1/ef/0",
                  bus.tx_valid, bus.tx_data, bus.rx_ready);
      end
      collect_read(1'b0, w, uns, rxh, cyc);
      n_cmp++;
      if (w !== 32'hDEADBEEF || cyc !== 4 || uns !== 0 || rxh !== 0) begin
         n_bad++;
         $display("FAIL rd_basic: word=%h cycles=%0d viol=%0d rxrdy_hi=%0d required deadbeef/4/0/0",
                  w, cyc, uns, rxh);
      end
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_basic_end: busy=%b txv=%b required 0/0", bus.busy, bus.tx_valid);
      end
   endtask

   task automatic test_read_stall();
      logic [31:0] w; int uns, rxh, cyc;
      logic [31:0] exp_w = 32'hDEADBEEF;
      poke_val[5] = exp_w; poke_en[5] = 1'b1;
      bus.tx_ready = 1'b0;
      send_byte(8'h05);
      poke_val[5] = 32'h0;
      collect_read(1'b1, w, uns, rxh, cyc);
      n_cmp++;
      if (w !== exp_w || uns !== 0 || rxh !== 0) begin
         n_bad++;
         $display("FAIL rd_stall_snapshot: word=%h viol=%0d rxrdy_hi=%0d required %h/0/0",
                  w, uns, rxh, exp_w);
      end
      poke_en[5] = 1'b0;
   endtask

   task automatic test_out_of_range();
      logic [31:0] w; int uns, rxh, cyc, p0;
      p0 = we_pulses;
      send_byte(8'h8F);
      for (int k = 0; k < 4; k++) send_byte(8'($urandom));
      tick();
      n_cmp++;
      if (we_pulses - p0 !== 0 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL oor_write: pulses=%0d busy=%b required 0/0", we_pulses - p0, bus.busy);
      end
      send_byte(8'h0F);
      collect_read(1'b0, w, uns, rxh, cyc);
      n_cmp++;
      if (w !== 32'h0 || uns !== 0) begin
         n_bad++; $display("FAIL oor_read: word=%h viol=%0d required 00000000/0", w, uns);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] w; int uns, rxh, cyc;
      send_byte(8'h81);
      send_byte(8'hAA);
      send_byte(8'hBB);
      tick();
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.reg_we, bus.byte_sel, bus.byte_in, bus.tx_valid, bus.tx_data, bus.busy} !== '0
          || bus.rx_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_outputs: we=%h sel=%h in=%h txv=%b busy=%b rdy=%b required 0s and rdy 1",
                  bus.reg_we, bus.byte_sel, bus.byte_in, bus.tx_valid, bus.busy, bus.rx_ready);
      end
      mregs[1][15:0] = 16'hBBAA;
      tick();
      rst = 1'b0;
      tick();
      bus.tx_ready = 1'b1;
      send_byte(8'h01);
      n_cmp++;
      if (bus.tx_valid !== 1'b1 || bus.busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_next_cmd: txv=%b busy=%b required 1/1", bus.tx_valid, bus.busy);
      end
      collect_read(1'b0, w, uns, rxh, cyc);
      n_cmp++;
      if (w !== mregs[1] || uns !== 0) begin
         n_bad++; $display("FAIL midrst_lanes: word=%h viol=%0d required %h/0", w, uns, mregs[1]);
      end
   endtask

   task automatic test_write_gaps();
      logic [31:0] w = $urandom;
      int p0, early;
      p0 = we_pulses; early = 0;
      send_byte(8'h83);
      for (int k = 0; k < 4; k++) begin
         send_byte(w[k*8 +: 8]);
         n_cmp++;
         if ({bus.reg_we, bus.byte_sel, bus.byte_in} !== {exp_onehot(3), 2'(k), w[k*8 +: 8]}) begin
            n_bad++;
            $display("FAIL wr_gap_lane%0d: we=%h sel=%0d in=%h required %h/%0d/%h", k,
                     bus.reg_we, bus.byte_sel, bus.byte_in, exp_onehot(3), k, w[k*8 +: 8]);
         end
         for (int g = 0; g < 3; g++) begin
            tick();
            if (bus.reg_we !== 8'h00) early++;
         end
      end
      mregs[3] = w;
      n_cmp++;
      if (we_pulses - p0 !== 4 || early !== 0) begin
         n_bad++;
         $display("FAIL wr_gap_pulses: pulses=%0d stray=%0d required 4/0", we_pulses - p0, early);
      end
   endtask

   task automatic test_random();
      logic [31:0] w; int uns, rxh, cyc, p0, idx;
      for (int f = 0; f < 40; f++) begin
         idx = $urandom_range(0, 15);
         repeat ($urandom_range(0, 2)) tick();
         if ($urandom_range(0, 1) == 1) begin
            w  = $urandom;
            p0 = we_pulses;
            send_byte(8'h80 | 8'($urandom_range(0, 7) << 4) | 8'(idx));
            for (int k = 0; k < 4; k++) begin
               repeat ($urandom_range(0, 2)) tick();
               send_byte(w[k*8 +: 8]);
            end
            tick();
            if (idx < NR) mregs[idx] = w;
            n_cmp++;
            if (we_pulses - p0 !== ((idx < NR) ? 4 : 0)) begin
               n_bad++;
               $display("FAIL rand_wr%0d: idx=%0d pulses=%0d required %0d", f, idx,
                        we_pulses - p0, (idx < NR) ? 4 : 0);
            end
         end else begin
            send_byte(8'($urandom_range(0, 7) << 4) | 8'(idx));
            collect_read(1'b1, w, uns, rxh, cyc);
            n_cmp++;
            if (w !== exp_read(idx) || uns !== 0 || rxh !== 0) begin
               n_bad++;
               $display("FAIL rand_rd%0d: idx=%0d word=%h viol=%0d required %h/0", f, idx, w, uns,
                        exp_read(idx));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w; int uns, rxh, cyc;
      for (int i = 0; i < NR; i++) begin
         bus.tx_ready = 1'b1;
         send_byte(8'(i));
         collect_read(1'b0, w, uns, rxh, cyc);
         n_cmp++;
         if (w !== mregs[i] || cyc !== 4) begin
            n_bad++;
            $display("FAIL b2b_rd%0d: word=%h cycles=%0d required %h/4", i, w, cyc, mregs[i]);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_b2b();
      test_read_basic();
      test_read_stall();
      test_out_of_range();
      test_reset_mid_frame();
      test_write_gaps();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/byte_reg_bridge.md
# byte_reg_bridge

Byte-stream command front-end for the controller's register bank. It accepts framed commands on a byte-wide valid/ready receive stream and turns each write command into four single-cycle byte writes (`we`/`byte_sel`/`byte_in`) toward the per-register byte-enable registers. Each read command snapshots one 32-bit register and returns it as four bytes on a transmit stream. It sits between the host link (UART/SPI byte receiver/transmitter) and the register bank.

## Interface
Parameters:
- `NUM_REGS`, 8: number of 32-bit registers addressed; legal range 1..16.
- `REG_WIDTH`, 32: register width; fixed at 32, giving 4 bytes per register.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: incoming command or data byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: bridge accepts `rx_data`.
- `tx_data` out 8: read-back byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: sink accepts `tx_data`.
- `reg_we` out NUM_REGS: one-hot byte-write strobe, one bit per register.
- `byte_sel` out 2: byte lane for the current write (0 = bits 7:0).
- `byte_in` out 8: byte to write.
- `reg_rdata` in NUM_REGS*32: flattened register contents; register i sits at bits [i*32 +: 32].
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Command byte format:
  - bit 7: 1 = write, 0 = read.
  - bits 6:4: reserved, ignored.
  - bits 3:0: register index `idx`.
- Handshakes:
  - An rx byte transfers when `rx_valid && rx_ready`.
  - A tx byte transfers when `tx_valid && tx_ready`.
- FSM states: IDLE, WR_DATA, RD_DATA. A 2-bit byte counter `cnt` tracks the byte position.
- IDLE:
  - `rx_ready` = 1.
  - On command accept: latch `idx`; set `cnt` = 0.
  - Write command → WR_DATA.
  - Read command → RD_DATA, and capture `reg_rdata[idx]` into a 32-bit snapshot in the same edge.
- WR_DATA:
  - `rx_ready` = 1.
  - Each accepted byte k (k = `cnt`) produces a write: `byte_sel` = k, `byte_in` = byte, `reg_we` = one-hot(`idx`).
  - After byte 3, return to IDLE.
  - Byte order is little-endian.
- RD_DATA:
  - `rx_ready` = 0.
  - `tx_data` = snapshot byte `cnt`, held stable while `tx_valid && !tx_ready`.
  - Each tx transfer increments `cnt`. The transfer of byte 3 drops `tx_valid` and returns to IDLE.
- Out-of-range index (`idx >= NUM_REGS`):
  - Write: the 4 data bytes are still consumed; `reg_we` stays all-zero.
  - Read: four bytes of 0x00 are returned.
- No abort or timeout exists. A frame always consumes exactly 1 + 4 rx bytes (write) or 1 rx byte plus 4 tx bytes (read).
- Reset values: state IDLE, `cnt` 0, snapshot 0, `reg_we` 0, `byte_sel` 0, `byte_in` 0, `tx_valid` 0, `tx_data` 0, `busy` 0. `rx_ready` = 1 in the cycle after `rst` deasserts.
- Reset mid-frame aborts the frame. Byte writes already issued remain in the target register. The next rx byte after reset is treated as a command.

## Timing
- `reg_we`, `byte_sel`, `byte_in`, `tx_data` and `tx_valid` are registered.
- `rx_ready` and `busy` are decoded directly from state.
- Write latency: data byte accepted at edge N → `reg_we`/`byte_sel`/`byte_in` valid for exactly one cycle after edge N, and cleared at edge N+1 unless another byte is accepted at N+1.
- Back-to-back data bytes give `reg_we` high on consecutive cycles with `byte_sel` 0,1,2,3.
- Throughput:
  - A write frame takes a minimum of 5 cycles.
  - A new command can be accepted the cycle after the 4th data byte.
- Read latency: command accepted at edge N → `tx_valid` = 1 with byte 0 after edge N.
- Read throughput: with `tx_ready` held at 1, bytes 0..3 transfer at edges N+1..N+4, and IDLE is re-entered after N+4.
- The snapshot isolates read data: register changes after the command edge do not affect returned bytes.

## Structure
- Package `byte_reg_pkg`:
  - state enum `bridge_state_t` {IDLE, WR_DATA, RD_DATA}.
  - constants `CMD_WR_BIT` = 7, `CMD_IDX_MSB` = 3, `REG_BYTES` = 4.
- Single flat module, no sub-module. The byte-enable register instances live in the parent register bank, one per `reg_we` bit, sharing `byte_sel`/`byte_in`.

## Test plan
- Write frame 0x82, 0x44, 0x33, 0x22, 0x11 sent back-to-back → `reg_we` = 0x04 on 4 consecutive cycles, `byte_sel` 0..3, `byte_in` 0x44,0x33,0x22,0x11; `busy` low afterwards.
- With `reg_rdata[5]` = 0xDEADBEEF, read 0x05, `tx_ready` = 1 → `tx_data` EF, BE, AD, DE on 4 consecutive cycles; `rx_ready` = 0 throughout.
- Same read with `tx_ready` toggling 0/1 and `reg_rdata[5]` changed to 0 after the command → `tx_data` held stable while stalled, returned bytes are still EF, BE, AD, DE.
- Write to 0x8F and read 0x0F with `NUM_REGS` = 8 → no `reg_we` pulse; read returns 00,00,00,00.
- `rst` asserted after the 2nd data byte of write 0x81 → outputs at reset values, the first two lanes of register 1 are written, and the next byte 0x01 is taken as a read command.
- `rx_valid` gaps of 3 idle cycles between write data bytes → exactly 4 `reg_we` pulses, each one cycle after its accepting edge.
